// File: rtl/misao_pkg.sv
// Shared types and constants for the MISA-O nibble-to-byte memory bridge.
package misao_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RESP,
    CAP,
    WRITE
  } bridge_state_e;

  localparam logic NIB_LO = 1'b0;
  localparam logic NIB_HI = 1'b1;

  localparam int NIB_W   = 4;
  localparam int BYTE_W  = 8;
  localparam int CADDR_W = 16;
  localparam int EADDR_W = 15;

  // Replace one nibble of a byte, leaving the companion nibble untouched.
  function automatic logic [BYTE_W-1:0] merge_nibble(input logic [BYTE_W-1:0] b,
                                                     input logic [NIB_W-1:0]  n,
                                                     input logic              sel);
    return (sel == NIB_HI) ? {n, b[3:0]} : {b[7:4], n};
  endfunction

endpackage

// File: rtl/misao_wait_timer.sv
// Wait-state counter for external accesses: cleared while idle, saturates at
// WAIT_STATES, and flags completion once the memory is also ready.
module misao_wait_timer
  import misao_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ext_ready,
  output logic done
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != WS_C) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == WS_C) & ext_ready;

endmodule

// File: rtl/misao_mem_bridge.sv
// Bridges the MISA-O 4-bit memory port to an 8-bit SRAM/ROM: one-byte read
// buffer, read-modify-write for nibble stores, wait states plus ready.
module misao_mem_bridge
  import misao_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter bit CACHE_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic [CADDR_W-1:0]   core_addr,
  input  logic                 core_rw,
  input  logic [NIB_W-1:0]     core_data_out,
  output logic [NIB_W-1:0]     core_data_in,
  output logic                 core_rd_en,
  output logic                 core_wr_en,
  output logic [EADDR_W-1:0]   ext_addr,
  output logic                 ext_cs,
  output logic                 ext_we,
  output logic [BYTE_W-1:0]    ext_wdata,
  input  logic [BYTE_W-1:0]    ext_rdata,
  input  logic                 ext_ready
);

  bridge_state_e        state, state_nx;
  logic [EADDR_W-1:0]   addr_q;
  logic                 rw_q;
  logic                 nib_q;
  logic [BYTE_W-1:0]    buf_q;
  logic [EADDR_W-1:0]   tag_q;
  logic                 buf_vld;
  logic                 busy;
  logic                 done;
  logic                 hit;

  assign busy = (state == READ) || (state == WRITE);

  // Writes always reuse a matching buffer as the merge source, even with the cache off.
  assign hit = buf_vld && (tag_q == core_addr[CADDR_W-1:1]) && (CACHE_EN || !core_rw);

  misao_wait_timer #(
    .WAIT_STATES (WAIT_STATES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (!busy),
    .ext_ready (ext_ready),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (core_req) begin
          if (hit) state_nx = core_rw ? RESP : CAP;
          else     state_nx = READ;
        end
      end
      READ:    if (done) state_nx = rw_q ? RESP : CAP;
      RESP:    state_nx = IDLE;
      CAP:     state_nx = WRITE;
      WRITE:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      rw_q    <= 1'b0;
      nib_q   <= NIB_LO;
      buf_q   <= '0;
      tag_q   <= '0;
      buf_vld <= 1'b0;
    end else begin
      if (state == IDLE && core_req) begin
        addr_q <= core_addr[CADDR_W-1:1];
        rw_q   <= core_rw;
        nib_q  <= core_addr[0];
      end
      if (state == READ && done) begin
        buf_q   <= ext_rdata;
        tag_q   <= addr_q;
        buf_vld <= 1'b1;
      end
      if (state == CAP) begin
        buf_q <= merge_nibble(buf_q, core_data_out, nib_q);
      end
    end
  end

  // Outputs decode straight from state, so an async reset drops the bus at once.
  assign ext_cs       = busy;
  assign ext_we       = (state == WRITE);
  assign ext_addr     = addr_q;
  assign ext_wdata    = (state == WRITE) ? buf_q : '0;
  assign core_rd_en   = (state == RESP);
  assign core_wr_en   = (state == CAP);
  assign core_data_in = (state == RESP) ? ((nib_q == NIB_HI) ? buf_q[7:4] : buf_q[3:0]) : '0;

endmodule

// File: tb/tb_misao_mem_bridge.sv
// Directed scoreboard bench: three bridges (WS=2 cached, WS=2 uncached, WS=0)
// each attached to its own behavioural byte memory.
module tb_misao_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  rw = '0;
  logic [15:0] caddr [3];
  logic [3:0]  cdo [3];
  logic [3:0]  cdi [3];
  logic [2:0]  rd_en, wr_en, cs, we;
  logic [14:0] eaddr [3];
  logic [7:0]  wdata [3];
  logic [7:0]  rdata [3];
  logic [2:0]  ready = 3'b111;
  logic [7:0]  mem [3][32768];

  logic [3:0]  sb [$];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_mem
    assign rdata[g] = mem[g][eaddr[g]];
  end

  misao_mem_bridge #(.WAIT_STATES(2), .CACHE_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .core_req(req[0]), .core_addr(caddr[0]), .core_rw(rw[0]),
    .core_data_out(cdo[0]), .core_data_in(cdi[0]), .core_rd_en(rd_en[0]), .core_wr_en(wr_en[0]),
    .ext_addr(eaddr[0]), .ext_cs(cs[0]), .ext_we(we[0]), .ext_wdata(wdata[0]),
    .ext_rdata(rdata[0]), .ext_ready(ready[0]));

  misao_mem_bridge #(.WAIT_STATES(2), .CACHE_EN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .core_req(req[1]), .core_addr(caddr[1]), .core_rw(rw[1]),
    .core_data_out(cdo[1]), .core_data_in(cdi[1]), .core_rd_en(rd_en[1]), .core_wr_en(wr_en[1]),
    .ext_addr(eaddr[1]), .ext_cs(cs[1]), .ext_we(we[1]), .ext_wdata(wdata[1]),
    .ext_rdata(rdata[1]), .ext_ready(ready[1]));

  misao_mem_bridge #(.WAIT_STATES(0), .CACHE_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .core_req(req[2]), .core_addr(caddr[2]), .core_rw(rw[2]),
    .core_data_out(cdo[2]), .core_data_in(cdi[2]), .core_rd_en(rd_en[2]), .core_wr_en(wr_en[2]),
    .ext_addr(eaddr[2]), .ext_cs(cs[2]), .ext_we(we[2]), .ext_wdata(wdata[2]),
    .ext_rdata(rdata[2]), .ext_ready(ready[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input int d, input string tag);
    check({tag, "_ctl"}, {cs[d], we[d], rd_en[d], wr_en[d]}, 4'h0);
    check({tag, "_dat"}, {cdi[d], eaddr[d], wdata[d]}, 27'h0);
  endtask

  // One core access, started from IDLE at a negedge and finished back in IDLE.
  task automatic access(input int d, input bit is_rd, input logic [15:0] a, input logic [3:0] wn,
                        input logic [7:0] exp_wb, input int exp_lat, input int exp_rd_cs,
                        input int exp_we, input int ready_low, input string tag);
    int lat = 0, rd_cs = 0, we_cnt = 0;
    bit strobe = 0, done = 0;
    logic [3:0] expn;
    req[d] = 1'b1; rw[d] = is_rd; caddr[d] = a; cdo[d] = wn; ready[d] = (ready_low == 0);
    @(posedge clk);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      req[d] = 1'b0;
      check({tag, "_excl"}, rd_en[d] & wr_en[d], 1'b0);
      if (!strobe) begin
        lat++;
        if (cs[d]) begin
          rd_cs++;
          ready[d] = (rd_cs > ready_low);
          check({tag, "_raddr"}, {we[d], eaddr[d]}, {1'b0, a[15:1]});
        end
        if (rd_en[d] || wr_en[d]) begin
          strobe = 1;
          ready[d] = 1'b1;
          check({tag, "_kind"}, {rd_en[d], wr_en[d]}, is_rd ? 2'b10 : 2'b01);
          check({tag, "_lat"}, lat, exp_lat);
          check({tag, "_rdcs"}, rd_cs, exp_rd_cs);
          if (is_rd) begin
            if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
            else begin
              expn = sb.pop_front();
              check({tag, "_data"}, cdi[d], expn);
            end
          end
        end
      end else if (is_rd) begin
        check({tag, "_rd_pulse"}, {rd_en[d], cs[d]}, 2'b00);
        done = 1;
      end else if (cs[d]) begin
        we_cnt++;
        check({tag, "_wbus"}, {we[d], eaddr[d], wdata[d]}, {1'b1, a[15:1], exp_wb});
        if (ready[d]) mem[d][a[15:1]] = exp_wb;
      end else begin
        check({tag, "_we_cycles"}, we_cnt, exp_we);
        check({tag, "_wr_pulse"}, {wr_en[d], we[d]}, 2'b00);
        done = 1;
      end
    end
    if (!done) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    bit seen;
    for (int d = 0; d < 3; d++) begin
      caddr[d] = '0; cdo[d] = '0;
      for (int i = 0; i < 32768; i++) mem[d][i] = 8'h00;
    end
    mem[0][15'h0000] = 8'hA5;
    mem[0][15'h0010] = 8'h3C;
    mem[0][15'h0018] = 8'h6B;
    mem[0][15'h0040] = 8'h55;
    mem[1][15'h7FFF] = 8'h81;
    mem[2][15'h0005] = 8'h9E;

    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) check_quiet(d, "reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    sb.push_back(4'h5);
    access(0, 1, 16'h0000, 4'h0, 8'h00, 4, 3, 0, 0, "rd_miss");
    sb.push_back(4'hA);
    access(0, 1, 16'h0001, 4'h0, 8'h00, 1, 0, 0, 0, "rd_hit");
    access(0, 0, 16'h0021, 4'h7, 8'h7C, 4, 3, 3, 0, "wr_merge");
    sb.push_back(4'hC);
    access(0, 1, 16'h0020, 4'h0, 8'h00, 1, 0, 0, 0, "rd_after_wr");
    sb.push_back(4'hB);
    access(0, 1, 16'h0030, 4'h0, 8'h00, 7, 6, 0, 5, "rdy_stretch");

    sb.push_back(4'h8);
    access(1, 1, 16'hFFFF, 4'h0, 8'h00, 4, 3, 0, 0, "top_hi");
    sb.push_back(4'h1);
    access(1, 1, 16'hFFFE, 4'h0, 8'h00, 4, 3, 0, 0, "top_lo_nocache");

    sb.push_back(4'hE);
    access(2, 1, 16'h000A, 4'h0, 8'h00, 2, 1, 0, 0, "ws0_rd_miss");
    access(2, 0, 16'h000B, 4'h3, 8'h3E, 1, 0, 1, 0, "ws0_wr_hit");
    sb.push_back(4'h3);
    access(2, 1, 16'h000B, 4'h0, 8'h00, 1, 0, 0, 0, "ws0_rd_hit");
    access(2, 0, 16'h0100, 4'h4, 8'h04, 2, 1, 1, 0, "ws0_wr_miss");
    sb.push_back(4'h4);
    access(2, 1, 16'h0100, 4'h0, 8'h00, 1, 0, 0, 0, "ws0_rd_b2b");

    // Stall a write miss in WRITE, then pull reset in the middle of it.
    req[0] = 1'b1; rw[0] = 1'b0; caddr[0] = 16'h0081; cdo[0] = 4'h9; ready[0] = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      req[0] = 1'b0;
      if (wr_en[0]) begin
        seen = 1;
        ready[0] = 1'b0;
      end
    end
    check("rstw_cap_seen", seen, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("rstw_stall", {cs[0], we[0], eaddr[0], wdata[0]}, {2'b11, 15'h0040, 8'h95});
    end
    #2 rst = 1'b0;
    #1 check_quiet(0, "rstw_async");
    @(negedge clk);
    check_quiet(0, "rstw_held");
    rst = 1'b1;
    ready[0] = 1'b1;
    @(negedge clk);
    sb.push_back(4'h5);
    access(0, 1, 16'h0081, 4'h0, 8'h00, 4, 3, 0, 0, "rstw_inval");
    sb.push_back(4'hA);
    access(0, 1, 16'h0001, 4'h0, 8'h00, 4, 3, 0, 0, "rstw_rd0001");

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/misao_mem_bridge.md
# misao_mem_bridge

Nibble-to-byte memory bridge between the MISA-O core's 4-bit memory port and an 8-bit external asynchronous-style SRAM/ROM with wait states and a ready line. It converts each core nibble access into a byte access. Reads go through a one-byte read buffer, so the companion nibble of the last byte returns without a bus cycle. Writes are done as read-modify-write. The bridge drives the core's read/write enables, which act as the core's completion strobes.

## Interface
- WAIT_STATES, 2: minimum extra cycles an external access is held; 0 is legal.
- CACHE_EN, 1: 1 lets reads hit the byte buffer; 0 forces every read to miss. The buffer is still used as the merge register.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- core_req  in  1  core has an access pending; sampled only in IDLE.
- core_addr  in  16  nibble address; [15:1] is the byte address, [0]=0 selects the low nibble.
- core_rw  in  1  1=read, 0=write; sampled only in IDLE.
- core_data_out  in  4  write nibble from the core; sampled in CAP.
- core_data_in  out  4  read nibble to the core; valid while core_rd_en=1.
- core_rd_en  out  1  one-cycle read completion strobe (core mem_enable_read).
- core_wr_en  out  1  one-cycle write-data capture strobe (core mem_enable_write).
- ext_addr  out  15  byte address.
- ext_cs  out  1  external chip select.
- ext_we  out  1  external write enable; only ever 1 while ext_cs=1.
- ext_wdata  out  8  write byte.
- ext_rdata  in  8  read byte.
- ext_ready  in  1  memory ready; tie to 1 if unused.

## Operation
- States:
  - IDLE: accept a request.
  - READ: external byte read.
  - RESP: read strobe cycle.
  - CAP: capture the core's write nibble.
  - WRITE: external byte write.
- Request latching: in IDLE with core_req=1, latch addr, rw and nibble select.
- Buffer hit: buf_valid & buf_tag==core_addr[15:1] & (CACHE_EN | write).
- IDLE transitions:
  - read hit -> RESP.
  - read miss -> READ.
  - write hit -> CAP.
  - write miss -> READ with the write flag set.
- READ:
  - ext_cs=1, ext_we=0, ext_addr = latched byte address.
  - Wait counter loads 0 on entry and saturates at WAIT_STATES.
  - The access completes on the first cycle with cnt==WAIT_STATES and ext_ready=1. On that cycle: buf <= ext_rdata, buf_tag <= address, buf_valid <= 1.
  - Then -> RESP if the request was a read, -> CAP if it was a write.
- RESP:
  - core_rd_en=1.
  - core_data_in = buf[7:4] if nibble select=1, else buf[3:0].
  - -> IDLE.
- CAP:
  - core_wr_en=1.
  - At the end of the cycle, core_data_out is merged into the selected nibble of buf.
  - -> WRITE.
- WRITE:
  - ext_cs=1, ext_we=1, ext_wdata=buf (merged byte).
  - Completes under the same counter/ready rule as READ, then -> IDLE.
  - Write-through: buf stays valid with the merged value.
- Ignored inputs: core_addr and core_rw changes outside IDLE; core_req is not sampled in RESP, so the core may update its address then.
- Addressing: byte address = core_addr[15:1], with no arithmetic. Nibble address 0xFFFF maps to byte 0x7FFF, high nibble; there is no wrap logic.
- Stalled memory: if ext_ready stays 0, the bridge remains in READ/WRITE with all outputs held, with no timeout.

## Timing
- Reset values: all outputs 0, state IDLE, buf_valid=0, buf/tag/counter 0.
- Reset mid-access: rst low forces ext_cs/ext_we low immediately, asynchronously. The access is abandoned and the buffer is invalidated.
- The request is sampled in IDLE at cycle N.
- Read hit: core_rd_en is high at N+1. The next request is sampled at N+2.
- Read miss with ext_ready=1:
  - READ spans N+1..N+1+WAIT_STATES.
  - core_rd_en is high at N+2+WAIT_STATES.
- Write miss: CAP at N+2+WAIT_STATES, WRITE spans WAIT_STATES+1 cycles, then IDLE.
- Write hit: CAP at N+1.
- Each ext_ready=0 cycle on the completing cycle adds one cycle.
- ext_addr, ext_wdata and ext_we are stable for the whole ext_cs assertion.
- core_rd_en and core_wr_en are never high together. Each is exactly one cycle per request.

## Structure
- Package misao_pkg holds:
  - the bridge state enum (IDLE, READ, RESP, CAP, WRITE);
  - nibble-select constants NIB_LO=0, NIB_HI=1;
  - the bus width constants (4, 8, 16, 15).
- Counter width is $clog2(WAIT_STATES+1), minimum 1.
- One sub-module: misao_wait_timer. It is a clear-on-start counter, saturating at WAIT_STATES, and outputs done = (cnt==WAIT_STATES) & ext_ready.
- Buffer, merge and FSM stay in misao_mem_bridge.

## Test plan
- **Reset mid-write:** rst=0 while in WRITE -> ext_cs=ext_we=0 in the same cycle, all outputs 0. After release, a read of 0x0001 misses (ext_cs asserted).
- **Read miss then hit** (WAIT_STATES=2, byte 0x0000=0xA5):
  - read 0x0000 -> core_data_in=0x5, core_rd_en at N+4;
  - then read 0x0001 -> 0xA at N+1 with no ext_cs.
- **Write merge** (byte 0x0010=0x3C): write 0x7 to nibble 0x0021 -> ext_addr=0x0010, ext_wdata=0x7C, ext_we held 3 cycles. A following read of 0x0020 hits and returns 0xC.
- **Ready stretch** (WAIT_STATES=2): ext_ready low for the first 5 READ cycles -> READ lasts 6 cycles, core_rd_en at N+7, ext_addr stable throughout.
- **Top address, CACHE_EN=0:** read 0xFFFF (byte 0x7FFF=0x81) -> ext_addr=0x7FFF, data 0x8. A repeated read of 0xFFFE asserts ext_cs again and returns 0x1.
- **Zero wait states** (WAIT_STATES=0): read miss -> core_rd_en at N+2. Back-to-back write then read keeps core_rd_en and core_wr_en mutually exclusive.
